// File: rtl/rx_frame_buffer_pkg.sv
// Shared ISO14443A definitions for the receive path: CRC_A constants, the CRC_A
// byte-update function (also used by the TX CRC generator) and the frame-buffer
// FSM state type.
package rx_frame_buffer_pkg;

  localparam logic [15:0] CRC_A_INIT           = 16'h6363;
  localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;

  typedef enum logic [1:0] {
    StIdle,
    StRx,
    StDrain
  } rx_state_e;

  // One CRC_A byte step: reflected polynomial, data consumed LSB first.
  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_A_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_frame_buffer_crc_a.sv
// Combinational CRC_A byte update.
//   crc_i  : current CRC register
//   data_i : byte to fold in (LSB first on air)
//   crc_o  : updated CRC
module rx_frame_buffer_crc_a
  import rx_frame_buffer_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc_a_byte(crc_i, data_i);

endmodule

// File: rtl/rx_frame_buffer.sv
// Single-frame receive store behind frame_decode. Captures one PCD frame, runs
// CRC_A over the complete bytes, reports frame status on end of comms and then
// streams the stored bytes out over valid/ready.
//   clk, rst_n          : carrier clock, async active-low reset
//   fd_*                : soc/eoc/data/error pulses from frame_decode
//   rx_frame_valid      : one-tick pulse when the rx_* status outputs update
//   rx_len_bytes ..     : status of the last completed frame
//   out_* / out_ready   : byte stream of the stored frame
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int unsigned BUFFER_BYTES = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  fd_soc,
  input  logic                                  fd_eoc,
  input  logic [7:0]                            fd_data,
  input  logic [2:0]                            fd_data_bits,
  input  logic                                  fd_data_valid,
  input  logic                                  fd_sequence_error,
  input  logic                                  fd_parity_error,
  output logic                                  rx_frame_valid,
  output logic [$clog2(BUFFER_BYTES+1)-1:0]     rx_len_bytes,
  output logic [2:0]                            rx_last_bits,
  output logic                                  rx_crc_ok,
  output logic                                  rx_error,
  output logic                                  rx_overflow,
  output logic [7:0]                            out_data,
  output logic [2:0]                            out_last_bits,
  output logic                                  out_last,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int unsigned LenW  = $clog2(BUFFER_BYTES + 1);
  localparam int unsigned AddrW = (BUFFER_BYTES > 1) ? $clog2(BUFFER_BYTES) : 1;
  localparam logic [LenW-1:0] MaxPtr = LenW'(BUFFER_BYTES);

  rx_state_e state_q, state_d;

  logic [LenW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LenW-1:0] rd_ptr_q, rd_ptr_d;
  logic            partial_q, partial_d;
  logic [2:0]      last_bits_q, last_bits_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     crc_q, crc_d;
  logic [15:0]     crc_upd;

  logic            frame_valid_q, frame_valid_d;
  logic [LenW-1:0] len_q, len_d;
  logic [2:0]      st_last_bits_q, st_last_bits_d;
  logic            crc_ok_q, crc_ok_d;
  logic            st_error_q, st_error_d;
  logic            st_ovf_q, st_ovf_d;
  logic            out_valid_q, out_valid_d;

  logic [7:0]      mem_q [BUFFER_BYTES];
  logic            mem_we;
  logic [LenW-1:0] full_bytes;
  logic            last_beat;
  logic            xfer;

  rx_frame_buffer_crc_a u_crc_a (
    .crc_i  (crc_q),
    .data_i (fd_data),
    .crc_o  (crc_upd)
  );

  assign xfer      = out_valid_q && out_ready;
  assign last_beat = out_valid_q && (rd_ptr_q == (len_q - LenW'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (fd_soc) begin
      state_d = StRx;
    end else begin
      unique case (state_q)
        StRx:    if (fd_eoc) state_d = (wr_ptr_d != '0) ? StDrain : StIdle;
        StDrain: if (xfer && last_beat) state_d = StIdle;
        default: ;
      endcase
    end
  end

  // Datapath next-state: capture, CRC, status latch and read pointer
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    partial_d      = partial_q;
    last_bits_d    = last_bits_q;
    err_d          = err_q;
    ovf_d          = ovf_q;
    crc_d          = crc_q;
    frame_valid_d  = 1'b0;
    len_d          = len_q;
    st_last_bits_d = st_last_bits_q;
    crc_ok_d       = crc_ok_q;
    st_error_d     = st_error_q;
    st_ovf_d       = st_ovf_q;
    out_valid_d    = out_valid_q;
    mem_we         = 1'b0;
    full_bytes     = '0;

    if (fd_soc) begin
      wr_ptr_d    = '0;
      partial_d   = 1'b0;
      err_d       = 1'b0;
      ovf_d       = 1'b0;
      crc_d       = CRC_A_INIT;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StRx: begin
          if (fd_data_valid) begin
            if (partial_q) begin
              // A partial byte must be the last one of a frame
              err_d = 1'b1;
            end else begin
              if (wr_ptr_q < MaxPtr) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + LenW'(1);
              end else begin
                ovf_d = 1'b1;
              end
              if (fd_data_bits == 3'd0) begin
                crc_d = crc_upd;
              end else begin
                partial_d   = 1'b1;
                last_bits_d = fd_data_bits;
              end
            end
          end
          if (fd_sequence_error || fd_parity_error) err_d = 1'b1;

          // Finalise on the already-updated values so same-cycle data counts
          if (fd_eoc) begin
            full_bytes     = wr_ptr_d - LenW'(partial_d);
            frame_valid_d  = 1'b1;
            len_d          = wr_ptr_d;
            st_last_bits_d = partial_d ? last_bits_d : 3'd0;
            crc_ok_d       = (crc_d == 16'h0000) && !partial_d && !ovf_d &&
                             (32'(full_bytes) >= 32'd3);
            st_error_d     = err_d;
            st_ovf_d       = ovf_d;
            if (wr_ptr_d != '0) begin
              rd_ptr_d    = '0;
              out_valid_d = 1'b1;
            end
          end
        end
        StDrain: begin
          if (xfer) begin
            if (last_beat) out_valid_d = 1'b0;
            else           rd_ptr_d    = rd_ptr_q + LenW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      partial_q      <= 1'b0;
      last_bits_q    <= 3'd0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      crc_q          <= CRC_A_INIT;
      frame_valid_q  <= 1'b0;
      len_q          <= '0;
      st_last_bits_q <= 3'd0;
      crc_ok_q       <= 1'b0;
      st_error_q     <= 1'b0;
      st_ovf_q       <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      partial_q      <= partial_d;
      last_bits_q    <= last_bits_d;
      err_q          <= err_d;
      ovf_q          <= ovf_d;
      crc_q          <= crc_d;
      frame_valid_q  <= frame_valid_d;
      len_q          <= len_d;
      st_last_bits_q <= st_last_bits_d;
      crc_ok_q       <= crc_ok_d;
      st_error_q     <= st_error_d;
      st_ovf_q       <= st_ovf_d;
      out_valid_q    <= out_valid_d;
    end
  end

  // Frame store, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AddrW-1:0]] <= fd_data;
  end

  // Outputs; stream fields are gated so they read zero when nothing is offered
  always_comb begin
    rx_frame_valid = frame_valid_q;
    rx_len_bytes   = len_q;
    rx_last_bits   = st_last_bits_q;
    rx_crc_ok      = crc_ok_q;
    rx_error       = st_error_q;
    rx_overflow    = st_ovf_q;
    out_valid      = out_valid_q;
    out_last       = last_beat;
    out_data       = out_valid_q ? mem_q[rd_ptr_q[AddrW-1:0]] : 8'h00;
    out_last_bits  = last_beat ? st_last_bits_q : 3'd0;
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Randomised bench for rx_frame_buffer with a queue-based frame model.
module tb_rx_frame_buffer;

  localparam int unsigned BufBytes = 4;
  localparam int unsigned LenW     = $clog2(BufBytes + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fd_soc = 1'b0, fd_eoc = 1'b0;
  logic [7:0]      fd_data = 8'h00;
  logic [2:0]      fd_data_bits = 3'd0;
  logic            fd_data_valid = 1'b0;
  logic            fd_sequence_error = 1'b0, fd_parity_error = 1'b0;
  logic            rx_frame_valid;
  logic [LenW-1:0] rx_len_bytes;
  logic [2:0]      rx_last_bits;
  logic            rx_crc_ok, rx_error, rx_overflow;
  logic [7:0]      out_data;
  logic [2:0]      out_last_bits;
  logic            out_last, out_valid;
  logic            out_ready = 1'b0;

  rx_frame_buffer #(.BUFFER_BYTES(BufBytes)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fd_soc            (fd_soc),
    .fd_eoc            (fd_eoc),
    .fd_data           (fd_data),
    .fd_data_bits      (fd_data_bits),
    .fd_data_valid     (fd_data_valid),
    .fd_sequence_error (fd_sequence_error),
    .fd_parity_error   (fd_parity_error),
    .rx_frame_valid    (rx_frame_valid),
    .rx_len_bytes      (rx_len_bytes),
    .rx_last_bits      (rx_last_bits),
    .rx_crc_ok         (rx_crc_ok),
    .rx_error          (rx_error),
    .rx_overflow       (rx_overflow),
    .out_data          (out_data),
    .out_last_bits     (out_last_bits),
    .out_last          (out_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Bit-serial CRC_A reference
  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  // Frame to send and model of what the block should report
  logic [7:0]  f_data[$];
  logic [2:0]  f_bits[$];
  logic [7:0]  exp_bytes[$];
  logic        m_partial, m_err, m_ovf;
  logic [2:0]  m_lb;
  logic [15:0] m_crc;
  int          m_full;

  task automatic model_byte(input logic [7:0] d, input logic [2:0] b);
    if (m_partial) begin
      m_err = 1'b1;
    end else begin
      if (exp_bytes.size() < BufBytes) exp_bytes.push_back(d);
      else m_ovf = 1'b1;
      if (b == 3'd0) begin
        m_crc = crc_ref(m_crc, d);
        m_full++;
      end else begin
        m_partial = 1'b1;
        m_lb      = b;
      end
    end
  endtask

  task automatic clear_inputs();
    fd_soc = 1'b0; fd_eoc = 1'b0; fd_data_valid = 1'b0;
    fd_sequence_error = 1'b0; fd_parity_error = 1'b0;
    fd_data = 8'h00; fd_data_bits = 3'd0;
  endtask

  // Returns on the negedge right after the eoc cycle's posedge.
  task automatic send_frame(input bit skip_soc, input bit eoc_with_last, input int err_at,
                            input bit seq_with_eoc);
    int n;
    n = f_data.size();
    if (!skip_soc) begin
      @(negedge clk); fd_soc = 1'b1;
      @(negedge clk); fd_soc = 1'b0;
    end
    exp_bytes.delete();
    m_partial = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_lb = 3'd0; m_crc = 16'h6363; m_full = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      fd_data_valid = 1'b1;
      fd_data       = f_data[i];
      fd_data_bits  = f_bits[i];
      model_byte(f_data[i], f_bits[i]);
      if (i == err_at) begin
        fd_parity_error = 1'b1;
        m_err = 1'b1;
      end
      if (i == n - 1 && eoc_with_last) begin
        fd_eoc = 1'b1;
        if (seq_with_eoc) begin
          fd_sequence_error = 1'b1;
          m_err = 1'b1;
        end
      end
      @(negedge clk);
      clear_inputs();
    end
    if (!(eoc_with_last && n > 0)) begin
      fd_eoc = 1'b1;
      if (seq_with_eoc) begin
        fd_sequence_error = 1'b1;
        m_err = 1'b1;
      end
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic check_status(input string tag);
    int len;
    len = exp_bytes.size();
    check_eq({tag, "_frame_valid"}, 32'(rx_frame_valid), 32'd1);
    check_eq({tag, "_len"}, 32'(rx_len_bytes), 32'(len));
    check_eq({tag, "_last_bits"}, 32'(rx_last_bits), m_partial ? 32'(m_lb) : 32'd0);
    check_eq({tag, "_crc_ok"}, 32'(rx_crc_ok),
             32'((m_crc == 16'h0000) && !m_partial && !m_ovf && (m_full >= 3)));
    check_eq({tag, "_error"}, 32'(rx_error), 32'(m_err));
    check_eq({tag, "_overflow"}, 32'(rx_overflow), 32'(m_ovf));
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(len > 0));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready held low for 3 cycles
  task automatic drain(input string tag, input int mode);
    int idx, cyc, len;
    logic rdy;
    idx = 0; cyc = 0; len = exp_bytes.size();
    while (idx < len && cyc < 200) begin
      unique case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 3);
      endcase
      out_ready = rdy;
      if (cyc > 0) check_eq({tag, "_fv_pulse"}, 32'(rx_frame_valid), 32'd0);
      check_eq({tag, "_sv"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_sd"}, 32'(out_data), 32'(exp_bytes[idx]));
      check_eq({tag, "_sl"}, 32'(out_last), 32'(idx == len - 1));
      check_eq({tag, "_slb"}, 32'(out_last_bits),
               (idx == len - 1 && m_partial) ? 32'(m_lb) : 32'd0);
      if (rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < len) check_eq({tag, "_drain_timeout"}, 32'(idx), 32'(len));
    check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_fv"}, 32'(rx_frame_valid), 32'd0);
  endtask

  task automatic set_frame(input logic [7:0] d[$], input logic [2:0] b[$]);
    f_data = d;
    f_bits = b;
  endtask

  initial begin
    int n, err_at, mode;
    bit ewl, seq;
    logic [15:0] c;
    logic [7:0]  held;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'({rx_frame_valid, rx_len_bytes, rx_last_bits, rx_crc_ok,
             rx_error, rx_overflow, out_data, out_last_bits, out_last, out_valid}), 32'd0);
    rst_n = 1'b1;

    // REQA: 7-bit short frame delivered with eoc
    set_frame('{8'h26}, '{3'd7});
    send_frame(0, 1, -1, 0);
    check_status("reqa");
    drain("reqa", 0);

    // HLTA with valid CRC
    set_frame('{8'h50, 8'h00, 8'h57, 8'hCD}, '{3'd0, 3'd0, 3'd0, 3'd0});
    send_frame(0, 0, -1, 0);
    check_eq("hlta_crc_ok_const", 32'(rx_crc_ok), 32'd1);
    check_status("hlta");
    drain("hlta", 2);

    // Corrupted CRC byte
    set_frame('{8'h50, 8'h00, 8'h57, 8'hCC}, '{3'd0, 3'd0, 3'd0, 3'd0});
    send_frame(0, 1, -1, 0);
    check_eq("hlta_bad_crc_ok", 32'(rx_crc_ok), 32'd0);
    check_status("hlta_bad");
    drain("hlta_bad", 1);

    // Overflow: five full bytes into a four-byte store
    set_frame('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
    send_frame(0, 0, -1, 0);
    check_eq("ovf_flag", 32'(rx_overflow), 32'd1);
    check_status("ovf");
    drain("ovf", 0);

    // Parity error on first byte
    set_frame('{8'h93, 8'h20}, '{3'd0, 3'd0});
    send_frame(0, 0, 0, 0);
    check_status("parity");
    drain("parity", 0);

    // Zero-byte frame with sequence error on eoc
    f_data.delete(); f_bits.delete();
    send_frame(0, 0, -1, 1);
    check_status("empty");
    @(negedge clk);
    check_eq("empty_fv_pulse", 32'(rx_frame_valid), 32'd0);
    check_eq("empty_no_valid", 32'(out_valid), 32'd0);

    // Abort a drain with soc, then receive a new frame
    set_frame('{8'hA1, 8'hB2, 8'hC3}, '{3'd0, 3'd0, 3'd0});
    send_frame(0, 0, -1, 0);
    check_status("abort_a");
    out_ready = 1'b1;
    check_eq("abort_b0", 32'(out_data), 32'hA1);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("abort_b1", 32'(out_data), 32'hB2);
    fd_soc = 1'b1;
    @(negedge clk);
    fd_soc = 1'b0;
    check_eq("abort_valid_drop", 32'(out_valid), 32'd0);
    check_eq("abort_len_held", 32'(rx_len_bytes), 32'd3);
    set_frame('{8'h50, 8'h00, 8'h57, 8'hCD}, '{3'd0, 3'd0, 3'd0, 3'd0});
    send_frame(1, 0, -1, 0);
    check_status("abort_new");
    drain("abort_new", 0);

    // Reset in the middle of reception
    @(negedge clk); fd_soc = 1'b1;
    @(negedge clk); fd_soc = 1'b0;
    fd_data_valid = 1'b1; fd_data = 8'h5A;
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("midrx_reset_outputs", 32'({rx_frame_valid, rx_len_bytes, rx_last_bits,
             rx_crc_ok, rx_error, rx_overflow, out_data, out_last_bits, out_last,
             out_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_frame('{8'h26}, '{3'd7});
    send_frame(0, 1, -1, 0);
    check_status("post_reset");
    drain("post_reset", 0);

    // Random frames
    for (int t = 0; t < 40; t++) begin
      f_data.delete(); f_bits.delete();
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 2);
        c = 16'h6363;
        for (int i = 0; i < n; i++) begin
          held = 8'($urandom);
          f_data.push_back(held); f_bits.push_back(3'd0);
          c = crc_ref(c, held);
        end
        f_data.push_back(c[7:0]);  f_bits.push_back(3'd0);
        f_data.push_back(c[15:8]); f_bits.push_back(3'd0);
      end else begin
        n = $urandom_range(0, 6);
        for (int i = 0; i < n; i++) begin
          f_data.push_back(8'($urandom));
          f_bits.push_back(($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
        end
        if (n > 0 && $urandom_range(0, 2) == 0) f_bits[n-1] = 3'($urandom_range(1, 7));
      end
      n      = f_data.size();
      err_at = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      seq    = ($urandom_range(0, 7) == 0);
      ewl    = 1'($urandom_range(0, 1));
      mode   = $urandom_range(0, 2);
      send_frame(0, ewl, err_at, seq);
      check_status($sformatf("rnd%0d", t));
      if (exp_bytes.size() > 0) begin
        drain($sformatf("rnd%0d", t), mode);
      end else begin
        @(negedge clk);
        check_eq($sformatf("rnd%0d_no_valid", t), 32'(out_valid), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
Sits directly downstream of frame_decode and consumes its soc/eoc/data/data_bits/data_valid/error pulses. It stores one PCD frame per reception and computes CRC_A over all complete bytes. At end of comms it reports frame status and streams the stored bytes to the command layer over a valid/ready interface. It is a single-frame store: the PCD does not send until the PICC responds.

Parameters:
BUFFER_BYTES, 32, maximum stored bytes per frame (CRC included); extra bytes are dropped and flagged.

Ports:
clk  input  1  13.56MHz recovered carrier clock
rst_n  input  1  asynchronous active-low reset
fd_soc  input  1  start of comms pulse
fd_eoc  input  1  end of comms pulse
fd_data  input  8  received byte, LSB first received
fd_data_bits  input  3  valid bits in fd_data; 0 = all 8
fd_data_valid  input  1  fd_data qualifier
fd_sequence_error  input  1  sequence error pulse
fd_parity_error  input  1  parity error pulse
rx_frame_valid  output  1  one-tick pulse: status outputs updated
rx_len_bytes  output  $clog2(BUFFER_BYTES+1)  stored bytes, partial byte included
rx_last_bits  output  3  valid bits of last stored byte; 0 = 8
rx_crc_ok  output  1  CRC_A residue check passed
rx_error  output  1  sequence/parity error seen, or protocol misuse
rx_overflow  output  1  more than BUFFER_BYTES bytes received
out_data  output  8  stream byte
out_last_bits  output  3  rx_last_bits when out_last, else 0
out_last  output  1  final byte of stream
out_valid  output  1  stream valid
out_ready  input  1  stream ready

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; wr_ptr/rd_ptr 0; crc 16'h6363. Memory contents are not reset.
- States: IDLE, RX, DRAIN.
- fd_soc in any state: go to RX. Clear wr_ptr, partial flag, err, ovf. Set crc=16'h6363 and out_valid=0 next cycle. Status outputs hold their old values until the next rx_frame_valid.
  - A soc during DRAIN aborts the drain.
  - A soc during RX restarts reception.
- RX, fd_data_valid with fd_data_bits==0:
  - If wr_ptr<BUFFER_BYTES: mem[wr_ptr]<=fd_data and wr_ptr++.
  - Otherwise set ovf; data is dropped.
  - crc<=crc_a_update(crc,fd_data) in both cases.
- RX, fd_data_valid with fd_data_bits!=0 (partial byte): store as above, set partial flag, latch last_bits. The byte is not fed to the CRC.
  - Any fd_data_valid after a partial byte: set err, drop the byte.
- RX, fd_sequence_error or fd_parity_error: set err.
- fd_eoc in RX (cycle N):
  - Same-cycle fd_data_valid and error inputs are applied first, then the frame is finalised. frame_decode delivers a partial byte together with eoc.
  - At N+1: rx_frame_valid=1 for one tick.
  - rx_len_bytes = final wr_ptr.
  - rx_last_bits = partial ? last_bits : 0.
  - rx_crc_ok = (final crc==16'h0000) && !partial && full-byte count>=3 && !ovf.
  - rx_error = err; rx_overflow = ovf.
  - If rx_len_bytes>0: state DRAIN, rd_ptr=0, out_valid=1 at N+1. Otherwise state IDLE.
- fd_eoc/fd_data_valid/errors while IDLE or DRAIN: ignored.
- DRAIN:
  - out_data=mem[rd_ptr]; out_last=(rd_ptr==rx_len_bytes-1).
  - Transfer occurs when out_valid&&out_ready: rd_ptr++.
  - After the transfer with out_last: out_valid=0, state IDLE.
  - out_data, out_last and out_last_bits are stable while out_valid&&!out_ready.
- CRC_A: reflected polynomial 16'h8408, init 16'h6363, no final xor, byte processed LSB first. Residue over data+CRC is 0.
- Widths: wr_ptr saturates at BUFFER_BYTES and never wraps.

Decomposition:
- ISO14443A_pkg gains: CRC_A_INIT=16'h6363, CRC_A_POLY_REFLECTED=16'h8408, and function crc_a_byte(crc,data) returning the 16-bit update. The function is shared with the future TX CRC generator.
- One sub-module, crc_a: combinational byte update wrapping the package function, instantiated once.
- Memory is a flop array of BUFFER_BYTES x 8 inside this module.

Test Plan:
- REQA: soc; eoc with data_valid, data=8'h26, data_bits=7 -> rx_frame_valid next cycle, len 1, last_bits 7, crc_ok 0, error 0. Stream one byte 8'h26, out_last=1, out_last_bits=7.
- HLTA: soc; bytes 50,00,57,CD; eoc -> len 4, crc_ok 1, error 0. Stream 50,00,57,CD with out_last on CD. Corrupting CD to CC -> crc_ok 0.
- Overflow: BUFFER_BYTES=4, 5 full bytes -> len 4, overflow 1, crc_ok 0. Only the first 4 bytes are streamed.
- Errors: parity_error after byte 1 then eoc -> error 1. Zero-byte frame (sequence_error with eoc) -> len 0, error 1, no out_valid.
- Backpressure/abort: out_ready low for 3 cycles -> out_data held. soc mid-drain -> out_valid 0 next cycle; new frame received correctly.
- Reset: assert rst_n low mid-RX -> all outputs 0 immediately. Next soc/eoc frame is correct.
